// File: rtl/rib_arbiter_if.sv
// Request/grant bus between the three masters and the arbiter.
// The arbiter uses the slave modport; the master modport drives requests and acks.
interface rib_arbiter_if;
  logic [2:0] req_i;
  logic       slv_ack_i;
  logic       err_clr_i;
  logic [2:0] grant_o;
  logic       hold_flag_o;
  logic       timeout_o;
  logic       err_o;
  logic       busy_o;

  modport master (
    output req_i, slv_ack_i, err_clr_i,
    input  grant_o, hold_flag_o, timeout_o, err_o, busy_o
  );

  modport slave (
    input  req_i, slv_ack_i, err_clr_i,
    output grant_o, hold_flag_o, timeout_o, err_o, busy_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// Three-master bus arbiter: m0 (ex) > m2 (jtag) > m1 (pc fetch), with a
// starvation override for m1 and a per-transaction ack timeout.
module rib_arbiter #(
  parameter logic [7:0] TMO_CYCLES   = 8'd255,
  parameter logic [3:0] STARVE_LIMIT = 4'd15
) (
  input  logic          clk,
  input  logic          rst,
  rib_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state, nxt_state;
  logic [2:0] grant, nxt_grant;
  logic [3:0] starve_cnt, nxt_starve, starve_win;
  logic [7:0] tmo_cnt, nxt_tmo;
  logic       hold, nxt_hold;
  logic       timeout;
  logic       err;
  logic       busy;
  logic [2:0] pick;
  logic       txn_end;
  logic       tmo_fire;
  logic       fire;

  // Arbitration decision on the current requests and the starve count it implies.
  always_comb begin
    pick = 3'b000;
    if (bus.req_i[1] && (starve_cnt == STARVE_LIMIT)) pick = 3'b010;
    else if (bus.req_i[0])                            pick = 3'b001;
    else if (bus.req_i[2])                            pick = 3'b100;
    else if (bus.req_i[1])                            pick = 3'b010;

    starve_win = starve_cnt;
    if (pick[1])
      starve_win = '0;
    else if (bus.req_i[1] && (starve_cnt != STARVE_LIMIT))
      starve_win = starve_cnt + 4'd1;
  end

  assign txn_end  = bus.slv_ack_i || ((bus.req_i & grant) == 3'b000);
  assign tmo_fire = (tmo_cnt == (TMO_CYCLES - 8'd1));

  // Next-state logic; an ending transaction (ack or abort) takes precedence over the timeout.
  always_comb begin
    nxt_state  = state;
    nxt_grant  = grant;
    nxt_tmo    = tmo_cnt;
    nxt_starve = starve_cnt;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_i != 3'b000) begin
          nxt_state  = ACTIVE;
          nxt_grant  = pick;
          nxt_starve = starve_win;
          nxt_tmo    = '0;
        end
      end
      ACTIVE: begin
        if (txn_end) begin
          nxt_grant  = pick;
          nxt_starve = starve_win;
          nxt_tmo    = '0;
          nxt_state  = (bus.req_i != 3'b000) ? ACTIVE : IDLE;
        end else if (tmo_fire) begin
          fire      = 1'b1;
          nxt_grant = '0;
          nxt_tmo   = '0;
          nxt_state = IDLE;
        end else begin
          nxt_tmo = tmo_cnt + 8'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    nxt_hold = nxt_grant[0] | nxt_grant[2] |
               ((nxt_state == ACTIVE) && !nxt_grant[1] && bus.req_i[1]);
  end

  // State, counters and all outputs registered together; a timeout set beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      hold       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      grant      <= nxt_grant;
      starve_cnt <= nxt_starve;
      tmo_cnt    <= nxt_tmo;
      hold       <= nxt_hold;
      timeout    <= fire;
      busy       <= (nxt_state == ACTIVE);
      if (fire)
        err <= 1'b1;
      else if (bus.err_clr_i)
        err <= 1'b0;
    end
  end

  assign bus.grant_o     = grant;
  assign bus.hold_flag_o = hold;
  assign bus.timeout_o   = timeout;
  assign bus.err_o       = err;
  assign bus.busy_o      = busy;

endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: stimulus pushes the expected post-edge
// outputs, an independent monitor pops and compares one entry per clock edge.
module tb_rib_arbiter;

  logic clk = 1'b0;
  logic rst;

  rib_arbiter_if bus();

  rib_arbiter #(.TMO_CYCLES(8'd255), .STARVE_LIMIT(4'd15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] grant;
    logic       hold;
    logic       tmo;
    logic       err;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic compare(input exp_t e);
    logic [6:0] act, req;
    act = {bus.grant_o, bus.hold_flag_o, bus.timeout_o, bus.err_o, bus.busy_o};
    req = {e.grant, e.hold, e.tmo, e.err, e.busy};
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got grant=%b hold=%b tmo=%b err=%b busy=%b, expected grant=%b hold=%b tmo=%b err=%b busy=%b",
               e.name, bus.grant_o, bus.hold_flag_o, bus.timeout_o, bus.err_o, bus.busy_o,
               e.grant, e.hold, e.tmo, e.err, e.busy);
    end
  endtask

  // Monitor: after each rising edge, check the entry queued for that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) compare(q.pop_front());
    end
  end

  // Drive inputs on the falling edge; they are consumed by the next rising edge.
  task automatic step(input logic [2:0] r, input logic a, input logic c);
    @(negedge clk);
    bus.req_i     = r;
    bus.slv_ack_i = a;
    bus.err_clr_i = c;
  endtask

  task automatic exp_push(input string name, input logic [2:0] g, input logic h,
                          input logic t, input logic e, input logic b);
    exp_t x;
    x.name = name; x.grant = g; x.hold = h; x.tmo = t; x.err = e; x.busy = b;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b0;
    bus.req_i     = 3'b000;
    bus.slv_ack_i = 1'b0;
    bus.err_clr_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [2:0] g;
    rst           = 1'b0;
    bus.req_i     = 3'b000;
    bus.slv_ack_i = 1'b0;
    bus.err_clr_i = 1'b0;

    // Reset state, even with requests present.
    step(3'b111, 1'b0, 1'b0);
    exp_push("reset_state", 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_i = 3'b000;

    // All three request; m0 first, then m2 once m0 acks and withdraws.
    do_reset();
    step(3'b111, 0, 0); exp_push("all_req_m0",     3'b001, 1, 0, 0, 1);
    step(3'b111, 0, 0); exp_push("m0_locked",      3'b001, 1, 0, 0, 1);
    step(3'b110, 1, 0); exp_push("ack_to_m2",      3'b100, 1, 0, 0, 1);
    step(3'b110, 0, 0); exp_push("m2_locked",      3'b100, 1, 0, 0, 1);
    step(3'b000, 0, 0); exp_push("abort_to_idle",  3'b000, 0, 0, 0, 0);
    step(3'b001, 0, 0); exp_push("m0_again",       3'b001, 1, 0, 0, 1);
    step(3'b000, 1, 0); exp_push("ack_to_idle",    3'b000, 0, 0, 0, 0);

    // m0 and m1 continuously, ack every cycle: m1 wins every 16th decision.
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      step(3'b011, 1, 0);
      g = ((k % 16) == 0) ? 3'b010 : 3'b001;
      exp_push($sformatf("starve_%0d", k), g, (g != 3'b010), 0, 0, 1);
    end

    // m2 never acked: timeout after 255 active cycles, then re-grant and clear.
    do_reset();
    step(3'b100, 0, 0); exp_push("tmo_grant", 3'b100, 1, 0, 0, 1);
    for (int k = 2; k <= 255; k++) step(3'b100, 0, 0);
    exp_push("tmo_last_active", 3'b100, 1, 0, 0, 1);
    step(3'b100, 0, 0); exp_push("tmo_fire",     3'b000, 0, 1, 1, 0);
    step(3'b100, 0, 0); exp_push("tmo_regrant",  3'b100, 1, 0, 1, 1);
    step(3'b000, 0, 1); exp_push("err_cleared",  3'b000, 0, 0, 0, 0);

    // Ack on the would-be firing cycle wins; then clear coincident with a timeout.
    do_reset();
    step(3'b001, 0, 0); exp_push("race_grant", 3'b001, 1, 0, 0, 1);
    for (int k = 2; k <= 255; k++) step(3'b001, 0, 0);
    step(3'b001, 1, 0); exp_push("ack_beats_tmo", 3'b001, 1, 0, 0, 1);
    for (int k = 257; k <= 510; k++) step(3'b001, 0, 0);
    step(3'b001, 0, 1); exp_push("set_beats_clr", 3'b000, 0, 1, 1, 0);

    // m2 aborts with m1 waiting: m1 granted next cycle, no error.
    do_reset();
    step(3'b110, 0, 0); exp_push("m2_grant",    3'b100, 1, 0, 0, 1);
    step(3'b010, 0, 0); exp_push("abort_to_m1", 3'b010, 0, 0, 0, 1);
    step(3'b010, 1, 0); exp_push("m1_regrant",  3'b010, 0, 0, 0, 1);
    step(3'b000, 0, 0); exp_push("m1_done",     3'b000, 0, 0, 0, 0);

    // Asynchronous reset between edges while active, then first decision after release.
    do_reset();
    step(3'b001, 0, 0); exp_push("pre_rst_grant", 3'b001, 1, 0, 0, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    e.name = "async_rst"; e.grant = 3'b000; e.hold = 0; e.tmo = 0; e.err = 0; e.busy = 0;
    compare(e);
    @(negedge clk);
    rst           = 1'b1;
    bus.req_i     = 3'b010;
    bus.slv_ack_i = 1'b0;
    exp_push("post_rst_m1", 3'b010, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
RIB_ARBITER -- requirements
Module: rib_arbiter

Interface
REQ-001 SHALL provide parameter TMO_CYCLES, default 8'd255: ACTIVE cycles allowed without slave ack before timeout (legal range 1..255).
REQ-002 SHALL provide parameter STARVE_LIMIT, default 4'd15: consecutive m1 losses before m1 is force-granted (legal range 1..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: port clk (input, 1) is the system clock, and port rst (input, 1) is the asynchronous active-low reset.
REQ-004 req_i  input  3  request from master 0 (ex), master 1 (pc fetch) and master 2 (jtag), bit n is master n.
REQ-005 slv_ack_i  input  1  ack of the slave addressed by the granted master.
REQ-006 err_clr_i  input  1  synchronous clear of err_o.
REQ-007 grant_o  output  3  one-hot registered grant, 3'b000 when idle.
REQ-008 hold_flag_o  output  1  pipeline hold; 1 when the grant is to m0 or m2, or when req_i[1]=0 is not the case and m1 is blocked.
REQ-009 timeout_o  output  1  one-cycle pulse on a transaction timeout.
REQ-010 err_o  output  1  sticky timeout flag.
REQ-011 busy_o  output  1  1 while in the ACTIVE state.

Function
REQ-012 SHALL implement the states IDLE and ACTIVE; grant_o, busy_o and hold_flag_o SHALL all be registered.
REQ-013 In IDLE with any req_i bit set, the arbiter SHALL decide and, on the next edge, go to ACTIVE with grant_o set (1-cycle grant latency).
REQ-014 Base priority SHALL be m0 > m2 > m1.
REQ-015 A starve counter SHALL increment, saturating at STARVE_LIMIT, at each decision where req_i[1]=1 and m1 loses.
REQ-016 The starve counter SHALL clear when m1 is granted.
REQ-017 When the starve counter equals STARVE_LIMIT and req_i[1]=1, m1 SHALL win that decision regardless of the other requests.
REQ-018 In ACTIVE the grant SHALL stay locked until the granted master's transaction ends.
REQ-019 Ending by ack: slv_ack_i=1 ends the transaction; in the same cycle the arbiter SHALL re-arbitrate on current req_i, with no bubble cycle.
REQ-020 Ending by ack: if req_i=0 at that point, the arbiter SHALL go to IDLE with grant_o=0.
REQ-021 Ending by abort: if the granted master's req bit drops before ack, the arbiter SHALL treat it as an end and re-arbitrate identically, with no error.
REQ-022 A timeout counter SHALL clear on entry to ACTIVE and on every grant change, and SHALL increment each ACTIVE cycle without ack.
REQ-023 When the timeout counter equals TMO_CYCLES-1 with no ack, the next edge SHALL set timeout_o=1 for 1 cycle, set err_o=1, set grant_o=0 and go to IDLE.
REQ-024 A timed-out master that still requests SHALL re-arbitrate from IDLE normally.
REQ-025 If ack arrives in the same cycle the timeout would fire, ack SHALL win and no timeout SHALL occur.
REQ-026 If err_clr_i=1 and a timeout fire in the same cycle, err_o SHALL be 1 (set wins).
REQ-027 hold_flag_o SHALL equal the next-state value of (grant is m0 or m2), ORed with (ACTIVE, grant not m1, req_i[1]=1).
REQ-028 grant_o SHALL never have more than one bit set, and SHALL never be nonzero in IDLE.

Reset
REQ-029 When rst=0, regardless of clk, the block SHALL immediately force state=IDLE, grant_o=3'b000, hold_flag_o=0, timeout_o=0, err_o=0, busy_o=0, and clear both counters.
REQ-030 Reset mid-ACTIVE SHALL drop the grant with no timeout pulse; the first decision after rst returns to 1 SHALL occur on the first rising clk edge.

Verification
REQ-031 req_i=3'b111 from IDLE, with ack on the 2nd ACTIVE cycle -> grant_o=001 one cycle after the request, then 100 on the cycle after the ack, hold_flag_o=1 throughout.
REQ-032 req_i=3'b011 held, with 1-cycle ack every transaction -> m0 granted 15 times, then grant_o=010 exactly once, starve counter back to 0, then m0 again.
REQ-033 req_i=3'b100, never ack, TMO_CYCLES=255 -> timeout_o pulses on the 256th cycle after the grant, err_o=1, grant_o=000; err_clr_i=1 for 1 cycle -> err_o=0.
REQ-034 Grant to m2, then req_i[2] drops before ack while req_i[1]=1 -> next cycle grant_o=010, err_o stays 0, timeout_o stays 0.
REQ-035 Ack and the timeout-fire condition in the same cycle -> timeout_o=0 and err_o unchanged; err_clr_i coincident with a timeout -> err_o=1.
REQ-036 rst asserted asynchronously mid-ACTIVE, between clk edges -> all outputs 0 before the next edge; after release with req_i=3'b010 -> grant_o=010 one cycle later.
